// File: rtl/rob_alloc_commit_if.sv
// rtl/rob_alloc_commit_if.sv - issue, regfile, CDB, dispatch and commit signal bundle for the reorder buffer
interface rob_alloc_commit_if #(
    parameter int ROB_ADD_W = 4,
    parameter int REG_ADD_W = 5,
    parameter int DAT_W     = 32,
    parameter int OP_W      = 6
);
    logic                 iFlush;
    logic                 iIS_En;
    logic                 iIS_EnRd;
    logic [REG_ADD_W-1:0] iIS_Rd;
    logic [REG_ADD_W-1:0] iIS_Rs1;
    logic [REG_ADD_W-1:0] iIS_Rs2;
    logic                 oIS_Full;
    logic [ROB_ADD_W-1:0] oRF_Qn;
    logic                 iRF_En;
    logic [ROB_ADD_W-1:0] iRF_Qs1;
    logic [ROB_ADD_W-1:0] iRF_Qs2;
    logic [DAT_W-1:0]     iRF_Vs1;
    logic [DAT_W-1:0]     iRF_Vs2;
    logic [OP_W-1:0]      iRF_Op;
    logic [DAT_W-1:0]     iRF_Pc;
    logic [DAT_W-1:0]     iRF_Imm;
    logic                 iCDB_En;
    logic [ROB_ADD_W-1:0] iCDB_Tag;
    logic [DAT_W-1:0]     iCDB_Val;
    logic                 oRS_En;
    logic [ROB_ADD_W-1:0] oRS_Dest;
    logic [ROB_ADD_W-1:0] oRS_Qj;
    logic [ROB_ADD_W-1:0] oRS_Qk;
    logic [DAT_W-1:0]     oRS_Vj;
    logic [DAT_W-1:0]     oRS_Vk;
    logic [OP_W-1:0]      oRS_Op;
    logic [DAT_W-1:0]     oRS_Pc;
    logic [DAT_W-1:0]     oRS_Imm;
    logic                 oRF_En;
    logic [ROB_ADD_W-1:0] oRF_Rd;
    logic [DAT_W-1:0]     oRF_Vd;

    modport master (
        output iFlush, iIS_En, iIS_EnRd, iIS_Rd, iIS_Rs1, iIS_Rs2,
        output iRF_En, iRF_Qs1, iRF_Qs2, iRF_Vs1, iRF_Vs2, iRF_Op, iRF_Pc, iRF_Imm,
        output iCDB_En, iCDB_Tag, iCDB_Val,
        input  oIS_Full, oRF_Qn,
        input  oRS_En, oRS_Dest, oRS_Qj, oRS_Qk, oRS_Vj, oRS_Vk, oRS_Op, oRS_Pc, oRS_Imm,
        input  oRF_En, oRF_Rd, oRF_Vd
    );

    modport slave (
        input  iFlush, iIS_En, iIS_EnRd, iIS_Rd, iIS_Rs1, iIS_Rs2,
        input  iRF_En, iRF_Qs1, iRF_Qs2, iRF_Vs1, iRF_Vs2, iRF_Op, iRF_Pc, iRF_Imm,
        input  iCDB_En, iCDB_Tag, iCDB_Val,
        output oIS_Full, oRF_Qn,
        output oRS_En, oRS_Dest, oRS_Qj, oRS_Qk, oRS_Vj, oRS_Vk, oRS_Op, oRS_Pc, oRS_Imm,
        output oRF_En, oRF_Rd, oRF_Vd
    );
endinterface

// File: rtl/rob_alloc_commit.sv
// rtl/rob_alloc_commit.sv - reorder buffer: tag reservation, operand resolution/dispatch, in-order commit
module rob_alloc_commit #(
    parameter int ROB_ADD_W = 4,
    parameter int REG_ADD_W = 5,
    parameter int DAT_W     = 32,
    parameter int OP_W      = 6
) (
    input  logic clk,
    input  logic rst,
    rob_alloc_commit_if.slave bus
);
    localparam int N = 1 << ROB_ADD_W;
    localparam int C = N - 1;

    typedef logic [ROB_ADD_W-1:0] tag_t;
    typedef logic [REG_ADD_W-1:0] reg_t;
    typedef logic [DAT_W-1:0]     dat_t;

    // Entry 0 is never allocated, so its slots simply stay idle.
    logic [N-1:0] busy_q, busy_d, rdy_q, rdy_d, enrd_q, enrd_d;
    reg_t         rd_q [N];
    reg_t         rd_d [N];
    dat_t         val_q [N];
    dat_t         val_d [N];
    tag_t         head_q, head_d, tail_q, tail_d, cnt_q, cnt_d;

    // One-deep record of the last reserve, waiting for the regfile operand packet.
    logic pend_vld_q, pend_vld_d;
    tag_t pend_tag_q, pend_tag_d;
    reg_t pend_rs1_q, pend_rs1_d, pend_rs2_q, pend_rs2_d;

    logic        rs_en_q, rs_en_d;
    tag_t        rs_dest_q, rs_dest_d, rs_qj_q, rs_qj_d, rs_qk_q, rs_qk_d;
    dat_t        rs_vj_q, rs_vj_d, rs_vk_q, rs_vk_d, rs_pc_q, rs_pc_d, rs_imm_q, rs_imm_d;
    logic [OP_W-1:0] rs_op_q, rs_op_d;
    logic        rf_en_q, rf_en_d;
    tag_t        rf_rd_q, rf_rd_d;
    dat_t        rf_vd_q, rf_vd_d;

    logic full, reserve, fill, commit;
    logic cdb_en;
    tag_t cdb_tag;
    dat_t cdb_val;

    assign cdb_en  = bus.iCDB_En;
    assign cdb_tag = bus.iCDB_Tag;
    assign cdb_val = bus.iCDB_Val;

    function automatic tag_t next_tag(input tag_t t);
        return (t == tag_t'(C)) ? tag_t'(1) : t + tag_t'(1);
    endfunction

    // Returns {pending tag, value}; a zero tag means the operand is ready.
    function automatic logic [ROB_ADD_W+DAT_W-1:0] resolve(input tag_t q, input dat_t v, input reg_t rs);
        if (q == tag_t'(0))                    return {tag_t'(0), v};
        else if (!busy_q[q] || rd_q[q] != rs)  return {tag_t'(0), v};
        else if (commit && head_q == q)        return {tag_t'(0), val_q[head_q]};
        else if (rdy_q[q])                     return {tag_t'(0), val_q[q]};
        else if (cdb_en && cdb_tag == q)       return {tag_t'(0), cdb_val};
        else                                   return {q, v};
    endfunction

    // Room is kept for the reserve whose fill is still in flight.
    assign full    = (cnt_q >= tag_t'(C - 1));
    assign reserve = bus.iIS_En && !full;
    assign fill    = bus.iRF_En && pend_vld_q;
    assign commit  = busy_q[head_q] && rdy_q[head_q];

    // Next-state for entries, pointers, dispatch packet and commit write; flush overrides all of it.
    always_comb begin
        busy_d = busy_q; rdy_d = rdy_q; enrd_d = enrd_q; rd_d = rd_q; val_d = val_q;
        head_d = head_q; tail_d = tail_q;
        cnt_d  = cnt_q + tag_t'(reserve) - tag_t'(commit);
        pend_vld_d = pend_vld_q; pend_tag_d = pend_tag_q; pend_rs1_d = pend_rs1_q; pend_rs2_d = pend_rs2_q;
        rs_en_d = fill;
        rs_dest_d = rs_dest_q; rs_qj_d = rs_qj_q; rs_qk_d = rs_qk_q; rs_vj_d = rs_vj_q; rs_vk_d = rs_vk_q;
        rs_op_d = rs_op_q; rs_pc_d = rs_pc_q; rs_imm_d = rs_imm_q;
        rf_en_d = commit && enrd_q[head_q] && (rd_q[head_q] != reg_t'(0));
        rf_rd_d = rf_rd_q; rf_vd_d = rf_vd_q;

        if (commit) begin
            busy_d[head_q] = 1'b0;
            head_d  = next_tag(head_q);
            rf_rd_d = tag_t'(rd_q[head_q]);
            rf_vd_d = val_q[head_q];
        end
        if (cdb_en && busy_q[cdb_tag]) begin
            rdy_d[cdb_tag] = 1'b1;
            val_d[cdb_tag] = cdb_val;
        end
        if (fill) begin
            pend_vld_d = 1'b0;
            rs_dest_d  = pend_tag_q;
            {rs_qj_d, rs_vj_d} = resolve(bus.iRF_Qs1, bus.iRF_Vs1, pend_rs1_q);
            {rs_qk_d, rs_vk_d} = resolve(bus.iRF_Qs2, bus.iRF_Vs2, pend_rs2_q);
            rs_op_d  = bus.iRF_Op;
            rs_pc_d  = bus.iRF_Pc;
            rs_imm_d = bus.iRF_Imm;
        end
        if (reserve) begin
            busy_d[tail_q] = 1'b1;
            rdy_d[tail_q]  = 1'b0;
            enrd_d[tail_q] = bus.iIS_EnRd;
            rd_d[tail_q]   = bus.iIS_Rd;
            tail_d     = next_tag(tail_q);
            pend_vld_d = 1'b1;
            pend_tag_d = tail_q;
            pend_rs1_d = bus.iIS_Rs1;
            pend_rs2_d = bus.iIS_Rs2;
        end
        if (bus.iFlush) begin
            busy_d = '0; rdy_d = '0;
            head_d = tag_t'(1); tail_d = tag_t'(1); cnt_d = '0;
            pend_vld_d = 1'b0;
            rs_en_d = 1'b0;
            rf_en_d = 1'b0;
            rf_rd_d = rf_rd_q; rf_vd_d = rf_vd_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0; rdy_q <= '0; enrd_q <= '0;
            for (int i = 0; i < N; i++) begin
                rd_q[i]  <= '0;
                val_q[i] <= '0;
            end
            head_q <= tag_t'(1); tail_q <= tag_t'(1); cnt_q <= '0;
            pend_vld_q <= 1'b0; pend_tag_q <= '0; pend_rs1_q <= '0; pend_rs2_q <= '0;
            rs_en_q <= 1'b0; rs_dest_q <= '0; rs_qj_q <= '0; rs_qk_q <= '0;
            rs_vj_q <= '0; rs_vk_q <= '0; rs_op_q <= '0; rs_pc_q <= '0; rs_imm_q <= '0;
            rf_en_q <= 1'b0; rf_rd_q <= '0; rf_vd_q <= '0;
        end else begin
            busy_q <= busy_d; rdy_q <= rdy_d; enrd_q <= enrd_d;
            rd_q <= rd_d; val_q <= val_d;
            head_q <= head_d; tail_q <= tail_d; cnt_q <= cnt_d;
            pend_vld_q <= pend_vld_d; pend_tag_q <= pend_tag_d; pend_rs1_q <= pend_rs1_d; pend_rs2_q <= pend_rs2_d;
            rs_en_q <= rs_en_d; rs_dest_q <= rs_dest_d; rs_qj_q <= rs_qj_d; rs_qk_q <= rs_qk_d;
            rs_vj_q <= rs_vj_d; rs_vk_q <= rs_vk_d; rs_op_q <= rs_op_d; rs_pc_q <= rs_pc_d; rs_imm_q <= rs_imm_d;
            rf_en_q <= rf_en_d; rf_rd_q <= rf_rd_d; rf_vd_q <= rf_vd_d;
        end
    end

    assign bus.oIS_Full = full;
    assign bus.oRF_Qn   = tail_q;
    assign bus.oRS_En   = rs_en_q;
    assign bus.oRS_Dest = rs_dest_q;
    assign bus.oRS_Qj   = rs_qj_q;
    assign bus.oRS_Qk   = rs_qk_q;
    assign bus.oRS_Vj   = rs_vj_q;
    assign bus.oRS_Vk   = rs_vk_q;
    assign bus.oRS_Op   = rs_op_q;
    assign bus.oRS_Pc   = rs_pc_q;
    assign bus.oRS_Imm  = rs_imm_q;
    assign bus.oRF_En   = rf_en_q;
    assign bus.oRF_Rd   = rf_rd_q;
    assign bus.oRF_Vd   = rf_vd_q;
endmodule

// File: tb/tb_rob_alloc_commit.sv
// tb/tb_rob_alloc_commit.sv - directed self-checking bench for rob_alloc_commit
module tb_rob_alloc_commit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rob_alloc_commit_if #(.ROB_ADD_W(4), .REG_ADD_W(5), .DAT_W(32), .OP_W(6)) bus ();

    rob_alloc_commit #(.ROB_ADD_W(4), .REG_ADD_W(5), .DAT_W(32), .OP_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iFlush = 0; bus.iIS_En = 0; bus.iIS_EnRd = 0; bus.iIS_Rd = 0; bus.iIS_Rs1 = 0; bus.iIS_Rs2 = 0;
        bus.iRF_En = 0; bus.iRF_Qs1 = 0; bus.iRF_Qs2 = 0; bus.iRF_Vs1 = 0; bus.iRF_Vs2 = 0;
        bus.iRF_Op = 0; bus.iRF_Pc = 0; bus.iRF_Imm = 0;
        bus.iCDB_En = 0; bus.iCDB_Tag = 0; bus.iCDB_Val = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.iIS_En = 1; bus.iIS_EnRd = 1; bus.iIS_Rd = rd; bus.iIS_Rs1 = rs1; bus.iIS_Rs2 = rs2;
    endtask

    task automatic fill(input logic [3:0] qs1, input logic [31:0] vs1, input logic [3:0] qs2, input logic [31:0] vs2);
        bus.iRF_En = 1; bus.iRF_Qs1 = qs1; bus.iRF_Vs1 = vs1; bus.iRF_Qs2 = qs2; bus.iRF_Vs2 = vs2;
        bus.iRF_Op = 6'h13; bus.iRF_Pc = 32'h100; bus.iRF_Imm = 32'h5;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.iCDB_En = 1; bus.iCDB_Tag = tag; bus.iCDB_Val = val;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        bus.iIS_En = 1; bus.iIS_EnRd = 1; bus.iIS_Rd = 5'd9;
        tick();
        tick();
        rst = 0;
        clear_inputs();
        checks++; if (bus.oRF_Qn !== 4'd1) begin failures++; $display("FAIL reset_qn got=%0h exp=1", bus.oRF_Qn); end
        checks++; if (bus.oIS_Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", bus.oIS_Full); end
        checks++; if (bus.oRS_En !== 1'b0 || bus.oRS_Dest !== 4'd0 || bus.oRS_Vj !== 32'd0) begin failures++; $display("FAIL reset_rs got=%0h/%0h/%0h exp=0/0/0", bus.oRS_En, bus.oRS_Dest, bus.oRS_Vj); end
        checks++; if (bus.oRF_En !== 1'b0 || bus.oRF_Rd !== 4'd0 || bus.oRF_Vd !== 32'd0) begin failures++; $display("FAIL reset_rf got=%0h/%0h/%0h exp=0/0/0", bus.oRF_En, bus.oRF_Rd, bus.oRF_Vd); end
    endtask

    task automatic test_basic();
        do_reset();
        issue(5'd1, 5'd0, 5'd0);
        checks++; if (bus.oRF_Qn !== 4'd1) begin failures++; $display("FAIL basic_qn got=%0h exp=1", bus.oRF_Qn); end
        tick();
        clear_inputs();
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        checks++; if (bus.oRS_En !== 1'b0) begin failures++; $display("FAIL basic_rs_early got=%0h exp=0", bus.oRS_En); end
        tick();
        clear_inputs();
        checks++; if (bus.oRS_En !== 1'b1 || bus.oRS_Dest !== 4'd1 || bus.oRS_Qj !== 4'd0 || bus.oRS_Vj !== 32'd0) begin failures++; $display("FAIL basic_dispatch got=%0h/%0h/%0h/%0h exp=1/1/0/0", bus.oRS_En, bus.oRS_Dest, bus.oRS_Qj, bus.oRS_Vj); end
        checks++; if (bus.oRS_Op !== 6'h13 || bus.oRS_Pc !== 32'h100 || bus.oRS_Imm !== 32'h5) begin failures++; $display("FAIL basic_packet got=%0h/%0h/%0h exp=13/100/5", bus.oRS_Op, bus.oRS_Pc, bus.oRS_Imm); end
        cdb(4'd1, 32'h55);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_En !== 1'b0) begin failures++; $display("FAIL basic_rs_pulse got=%0h exp=0", bus.oRS_En); end
        tick();
        checks++; if (bus.oRF_En !== 1'b1 || bus.oRF_Rd !== 4'd1 || bus.oRF_Vd !== 32'h55) begin failures++; $display("FAIL basic_commit got=%0h/%0h/%0h exp=1/1/55", bus.oRF_En, bus.oRF_Rd, bus.oRF_Vd); end
        tick();
        checks++; if (bus.oRF_En !== 1'b0 || bus.oRF_Qn !== 4'd2) begin failures++; $display("FAIL basic_after got=%0h/%0h exp=0/2", bus.oRF_En, bus.oRF_Qn); end
    endtask

    task automatic test_dependency();
        do_reset();
        issue(5'd3, 5'd0, 5'd0);
        tick();
        clear_inputs();
        fill(4'd0, 32'd1, 4'd0, 32'd2);
        issue(5'd4, 5'd3, 5'd0);
        checks++; if (bus.oRF_Qn !== 4'd2) begin failures++; $display("FAIL dep_qn got=%0h exp=2", bus.oRF_Qn); end
        tick();
        clear_inputs();
        checks++; if (bus.oRS_En !== 1'b1 || bus.oRS_Dest !== 4'd1 || bus.oRS_Vj !== 32'd1 || bus.oRS_Vk !== 32'd2) begin failures++; $display("FAIL dep_a got=%0h/%0h/%0h/%0h exp=1/1/1/2", bus.oRS_En, bus.oRS_Dest, bus.oRS_Vj, bus.oRS_Vk); end
        fill(4'd1, 32'hDEAD, 4'd0, 32'h10);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_Dest !== 4'd2 || bus.oRS_Qj !== 4'd1 || bus.oRS_Qk !== 4'd0 || bus.oRS_Vk !== 32'h10) begin failures++; $display("FAIL dep_b_pending got=%0h/%0h/%0h/%0h exp=2/1/0/10", bus.oRS_Dest, bus.oRS_Qj, bus.oRS_Qk, bus.oRS_Vk); end
        issue(5'd5, 5'd3, 5'd0);
        checks++; if (bus.oRF_Qn !== 4'd3) begin failures++; $display("FAIL dep_qn3 got=%0h exp=3", bus.oRF_Qn); end
        tick();
        clear_inputs();
        fill(4'd1, 32'hDEAD, 4'd0, 32'd0);
        cdb(4'd1, 32'd7);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_Dest !== 4'd3 || bus.oRS_Qj !== 4'd0 || bus.oRS_Vj !== 32'd7) begin failures++; $display("FAIL dep_cdb_bypass got=%0h/%0h/%0h exp=3/0/7", bus.oRS_Dest, bus.oRS_Qj, bus.oRS_Vj); end
        tick();
        checks++; if (bus.oRF_En !== 1'b1 || bus.oRF_Rd !== 4'd3 || bus.oRF_Vd !== 32'd7) begin failures++; $display("FAIL dep_commit got=%0h/%0h/%0h exp=1/3/7", bus.oRF_En, bus.oRF_Rd, bus.oRF_Vd); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            issue(5'd2, 5'd0, 5'd0);
            checks++; if (bus.oIS_Full !== 1'b0 || bus.oRF_Qn !== 4'(i + 1)) begin failures++; $display("FAIL full_fill_%0d got=%0h/%0h exp=0/%0h", i, bus.oIS_Full, bus.oRF_Qn, i + 1); end
            tick();
        end
        clear_inputs();
        checks++; if (bus.oIS_Full !== 1'b1 || bus.oRF_Qn !== 4'd15) begin failures++; $display("FAIL full_at14 got=%0h/%0h exp=1/f", bus.oIS_Full, bus.oRF_Qn); end
        issue(5'd2, 5'd0, 5'd0);
        tick();
        clear_inputs();
        checks++; if (bus.oRF_Qn !== 4'd15 || bus.oIS_Full !== 1'b1) begin failures++; $display("FAIL full_ignored got=%0h/%0h exp=f/1", bus.oRF_Qn, bus.oIS_Full); end
        cdb(4'd1, 32'h11);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.oIS_Full !== 1'b0 || bus.oRF_En !== 1'b1 || bus.oRF_Vd !== 32'h11) begin failures++; $display("FAIL full_release got=%0h/%0h/%0h exp=0/1/11", bus.oIS_Full, bus.oRF_En, bus.oRF_Vd); end
        issue(5'd2, 5'd0, 5'd0);
        checks++; if (bus.oRF_Qn !== 4'd15) begin failures++; $display("FAIL full_tag15 got=%0h exp=f", bus.oRF_Qn); end
        tick();
        clear_inputs();
        checks++; if (bus.oRF_Qn !== 4'd1 || bus.oIS_Full !== 1'b1) begin failures++; $display("FAIL full_wrap got=%0h/%0h exp=1/1", bus.oRF_Qn, bus.oIS_Full); end
    endtask

    task automatic test_stale();
        do_reset();
        issue(5'd3, 5'd0, 5'd0);
        tick();
        clear_inputs();
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        cdb(4'd1, 32'h33);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.oRF_En !== 1'b1 || bus.oRF_Vd !== 32'h33) begin failures++; $display("FAIL stale_commit got=%0h/%0h exp=1/33", bus.oRF_En, bus.oRF_Vd); end
        issue(5'd6, 5'd3, 5'd0);
        tick();
        clear_inputs();
        fill(4'd1, 32'h33, 4'd0, 32'd0);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_Dest !== 4'd2 || bus.oRS_Qj !== 4'd0 || bus.oRS_Vj !== 32'h33) begin failures++; $display("FAIL stale_not_busy got=%0h/%0h/%0h exp=2/0/33", bus.oRS_Dest, bus.oRS_Qj, bus.oRS_Vj); end
        bus.iFlush = 1;
        tick();
        clear_inputs();
        checks++; if (bus.oRF_Qn !== 4'd1) begin failures++; $display("FAIL stale_flush_qn got=%0h exp=1", bus.oRF_Qn); end
        issue(5'd5, 5'd0, 5'd0);
        tick();
        clear_inputs();
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        issue(5'd7, 5'd3, 5'd0);
        tick();
        clear_inputs();
        fill(4'd1, 32'h9, 4'd0, 32'd0);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_Dest !== 4'd2 || bus.oRS_Qj !== 4'd0 || bus.oRS_Vj !== 32'h9) begin failures++; $display("FAIL stale_rd_mismatch got=%0h/%0h/%0h exp=2/0/9", bus.oRS_Dest, bus.oRS_Qj, bus.oRS_Vj); end
    endtask

    task automatic test_commit_x0_bypass();
        do_reset();
        issue(5'd0, 5'd0, 5'd0);
        tick();
        clear_inputs();
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        cdb(4'd1, 32'hFF);
        tick();
        clear_inputs();
        tick();
        checks++; if (bus.oRF_En !== 1'b0 || bus.oRF_Vd !== 32'hFF || bus.oRF_Rd !== 4'd0) begin failures++; $display("FAIL x0_commit got=%0h/%0h/%0h exp=0/ff/0", bus.oRF_En, bus.oRF_Vd, bus.oRF_Rd); end
        issue(5'd4, 5'd0, 5'd0);
        tick();
        clear_inputs();
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        cdb(4'd2, 32'h77);
        issue(5'd6, 5'd4, 5'd0);
        tick();
        clear_inputs();
        fill(4'd2, 32'hBAD, 4'd0, 32'd0);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_Dest !== 4'd3 || bus.oRS_Qj !== 4'd0 || bus.oRS_Vj !== 32'h77) begin failures++; $display("FAIL bypass_commit got=%0h/%0h/%0h exp=3/0/77", bus.oRS_Dest, bus.oRS_Qj, bus.oRS_Vj); end
        checks++; if (bus.oRF_En !== 1'b1 || bus.oRF_Rd !== 4'd4 || bus.oRF_Vd !== 32'h77) begin failures++; $display("FAIL x0_head_advance got=%0h/%0h/%0h exp=1/4/77", bus.oRF_En, bus.oRF_Rd, bus.oRF_Vd); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(5'd1, 5'd0, 5'd0);
        tick();
        issue(5'd2, 5'd0, 5'd0);
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        issue(5'd3, 5'd0, 5'd0);
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_En !== 1'b1 || bus.oRS_Dest !== 4'd2) begin failures++; $display("FAIL flush_pre got=%0h/%0h exp=1/2", bus.oRS_En, bus.oRS_Dest); end
        bus.iFlush = 1;
        fill(4'd0, 32'd0, 4'd0, 32'd0);
        cdb(4'd1, 32'h99);
        issue(5'd4, 5'd0, 5'd0);
        tick();
        clear_inputs();
        checks++; if (bus.oRS_En !== 1'b0 || bus.oRF_En !== 1'b0 || bus.oRF_Qn !== 4'd1 || bus.oIS_Full !== 1'b0) begin failures++; $display("FAIL flush_state got=%0h/%0h/%0h/%0h exp=0/0/1/0", bus.oRS_En, bus.oRF_En, bus.oRF_Qn, bus.oIS_Full); end
        for (int i = 0; i < 3; i++) begin
            fill(4'd0, 32'd0, 4'd0, 32'd0);
            tick();
            clear_inputs();
            checks++; if (bus.oRS_En !== 1'b0 || bus.oRF_En !== 1'b0) begin failures++; $display("FAIL flush_quiet_%0d got=%0h/%0h exp=0/0", i, bus.oRS_En, bus.oRF_En); end
        end
        issue(5'd5, 5'd0, 5'd0);
        checks++; if (bus.oRF_Qn !== 4'd1) begin failures++; $display("FAIL flush_reissue got=%0h exp=1", bus.oRF_Qn); end
        tick();
        clear_inputs();
        checks++; if (bus.oRF_Qn !== 4'd2) begin failures++; $display("FAIL flush_next got=%0h exp=2", bus.oRF_Qn); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_basic();
        test_dependency();
        test_full_wrap();
        test_stale();
        test_commit_x0_bypass();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
